// File: rtl/sudoku_iter_ctrl.sv
// Sudoku iterative elimination controller.
// Repeatedly feeds the current candidate-exclusion mask through an external
// combinational elimination stage until the mask converges, a cell runs out of
// candidates (conflict), or MAX_ITER passes elapse (timeout).
// Optional macro SUDOKU_ITER_PIPE_EN registers the stage result and inserts a
// WAIT cycle before every update, so each pass takes two cycles.
module sudoku_iter_ctrl #(
  parameter int unsigned MAX_ITER = 32,
  parameter int unsigned ITER_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [728:0]      mask_in,
  output logic [728:0]      stg_mask_out,
  input  logic [728:0]      stg_mask_in,
  output logic              busy,
  output logic              done,
  output logic              solved,
  output logic              conflict,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
`ifdef SUDOKU_ITER_PIPE_EN
  localparam logic [1:0] StWait = 2'd2;
`endif
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [ITER_W-1:0] MaxCnt = ITER_W'(MAX_ITER);

  logic [1:0]        state_q, state_d;
  logic [728:0]      cur_mask_q, cur_mask_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic              solved_q, solved_d;
  logic              conflict_q, conflict_d;
  logic              timeout_q, timeout_d;

  // Stage result that the RUN cycle evaluates and commits.
  logic [728:0]      eval_mask;
  logic [ITER_W-1:0] iter_inc;
  logic              any_full;
  logic              all_eight;
  logic [8:0]        grp;
  logic [8:0]        inv;

`ifdef SUDOKU_ITER_PIPE_EN
  logic [728:0] stg_reg_q;

  // Capture the stage result during WAIT; RUN then works from this copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_reg_q <= '0;
    end else if (state_q == StWait) begin
      stg_reg_q <= stg_mask_in;
    end
  end

  assign eval_mask = stg_reg_q;
`else
  assign eval_mask = stg_mask_in;
`endif

  // Per-cell classification of the candidate mask: full (conflict) or single-candidate.
  always_comb begin
    any_full  = 1'b0;
    all_eight = 1'b1;
    grp       = '0;
    inv       = '0;
    for (int c = 0; c < 81; c++) begin
      grp = eval_mask[c*9 +: 9];
      inv = ~grp;
      if (grp == 9'h1ff) begin
        any_full = 1'b1;
      end
      // Exactly one zero bit: the inverted group is a non-zero power of two.
      if (!((inv != 9'd0) && ((inv & (inv - 9'd1)) == 9'd0))) begin
        all_eight = 1'b0;
      end
    end
  end

  // Saturating pass counter increment.
  assign iter_inc = (iter_cnt_q == MaxCnt) ? iter_cnt_q : iter_cnt_q + ITER_W'(1);

  // Next-state and result logic.
  always_comb begin
    state_d    = state_q;
    cur_mask_d = cur_mask_q;
    iter_cnt_d = iter_cnt_q;
    solved_d   = solved_q;
    conflict_d = conflict_q;
    timeout_d  = timeout_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          cur_mask_d = mask_in;
          iter_cnt_d = '0;
          solved_d   = 1'b0;
          conflict_d = 1'b0;
          timeout_d  = 1'b0;
`ifdef SUDOKU_ITER_PIPE_EN
          state_d    = StWait;
`else
          state_d    = StRun;
`endif
        end
      end
      StRun: begin
        cur_mask_d = eval_mask;
        iter_cnt_d = iter_inc;
        if (any_full) begin
          conflict_d = 1'b1;
          solved_d   = 1'b0;
          state_d    = StDone;
        end else if (eval_mask == cur_mask_q) begin
          solved_d = all_eight;
          state_d  = StDone;
        end else if (iter_inc == MaxCnt) begin
          timeout_d = 1'b1;
          solved_d  = all_eight;
          state_d   = StDone;
        end else begin
`ifdef SUDOKU_ITER_PIPE_EN
          state_d = StWait;
`else
          state_d = StRun;
`endif
        end
      end
`ifdef SUDOKU_ITER_PIPE_EN
      StWait: begin
        state_d = StRun;
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cur_mask_q <= '0;
      iter_cnt_q <= '0;
      solved_q   <= 1'b0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_mask_q <= cur_mask_d;
      iter_cnt_q <= iter_cnt_d;
      solved_q   <= solved_d;
      conflict_q <= conflict_d;
      timeout_q  <= timeout_d;
    end
  end

  assign stg_mask_out = cur_mask_q;
`ifdef SUDOKU_ITER_PIPE_EN
  assign busy = (state_q == StRun) || (state_q == StWait);
`else
  assign busy = (state_q == StRun);
`endif
  assign done     = (state_q == StDone);
  assign solved   = solved_q;
  assign conflict = conflict_q;
  assign timeout  = timeout_q;
  assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_sudoku_iter_ctrl.sv
// Scoreboard bench for sudoku_iter_ctrl with a behavioural elimination stage.
module tb_sudoku_iter_ctrl;

  localparam int unsigned MAX_ITER = 32;
  localparam int unsigned ITER_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [728:0]      mask_in;
  logic [728:0]      stg_mask_out;
  logic [728:0]      stg_mask_in;
  logic              busy, done, solved, conflict, timeout;
  logic [ITER_W-1:0] iter_cnt;

  sudoku_iter_ctrl #(
    .MAX_ITER (MAX_ITER),
    .ITER_W   (ITER_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mask_in      (mask_in),
    .stg_mask_out (stg_mask_out),
    .stg_mask_in  (stg_mask_in),
    .busy         (busy),
    .done         (done),
    .solved       (solved),
    .conflict     (conflict),
    .timeout      (timeout),
    .iter_cnt     (iter_cnt)
  );

  always #5 clk = ~clk;

  // Stage model: 0 identity, 1 conflict on third pass, 2 sets one more bit per pass.
  int   mode;
  logic found;
  always_comb begin
    stg_mask_in = stg_mask_out;
    found       = 1'b0;
    case (mode)
      1: begin
        if (!stg_mask_out[0])      stg_mask_in[0] = 1'b1;
        else if (!stg_mask_out[9]) stg_mask_in[9] = 1'b1;
        else                       stg_mask_in[8:0] = 9'h1ff;
      end
      2: begin
        for (int c = 0; c < 81; c++) begin
          if (!found && !stg_mask_out[c*9]) begin
            stg_mask_in[c*9] = 1'b1;
            found = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [ITER_W-1:0] iter;
    logic              solved;
    logic              conflict;
    logic              timeout;
    int                start_cyc;
    string             name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [728:0] act, input logic [728:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input int n);
`ifdef SUDOKU_ITER_PIPE_EN
    return 1 + 2 * n;
`else
    return 1 + n;
`endif
  endfunction

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending solve");
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_iter"}, iter_cnt, e.iter);
        check({e.name, "_solved"}, solved, e.solved);
        check({e.name, "_conflict"}, conflict, e.conflict);
        check({e.name, "_timeout"}, timeout, e.timeout);
        check({e.name, "_busy_in_done"}, busy, 1'b0);
        check({e.name, "_latency"}, 729'(cyc - e.start_cyc), 729'(exp_lat(int'(e.iter))));
      end
    end
  end

  task automatic run(input int m, input logic [728:0] min, input logic [ITER_W-1:0] ei,
                     input logic es, input logic ec, input logic et,
                     input logic [728:0] emask, input int poke, input string nm);
    exp_t e;
    int   n0;
    bit   seen;
    @(negedge clk);
    mode    = m;
    mask_in = min;
    e.iter = ei; e.solved = es; e.conflict = ec; e.timeout = et;
    e.start_cyc = cyc; e.name = nm;
    q.push_back(e);
    n0    = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      start = 1'b0;
      if (done_cnt > n0) begin
        seen = 1'b1;
        break;
      end
      // Start issued while busy, with a different mask; must have no effect.
      if (poke > 0 && k == poke) begin
        mask_in = '1;
        start   = 1'b1;
      end
    end
    start = 1'b0;
    if (!seen) begin
      vectors++;
      errors++;
      $display("FAIL %s_done_wait: got no done expected done within 300 cycles", nm);
      q.delete();
      return;
    end
    @(negedge clk);
    #1;
    check({nm, "_done_pulse"}, done, 1'b0);
    check({nm, "_idle_busy"}, busy, 1'b0);
    check({nm, "_hold_iter"}, iter_cnt, ei);
    check({nm, "_hold_solved"}, solved, es);
    check({nm, "_hold_conflict"}, conflict, ec);
    check({nm, "_hold_timeout"}, timeout, et);
    check({nm, "_hold_mask"}, stg_mask_out, emask);
  endtask

  logic [728:0] grid, bad, add32, zero_m, conf_m;

  initial begin
    mode    = 0;
    start   = 1'b0;
    mask_in = '0;
    rst_n   = 1'b0;
    zero_m  = '0;
    for (int c = 0; c < 81; c++) grid[c*9 +: 9] = ~(9'd1 << (c % 9));
    bad = grid;
    bad[40*9 +: 9] = 9'h1ff;
    add32 = '0;
    for (int c = 0; c < 32; c++) add32[c*9] = 1'b1;
    conf_m = '0;
    conf_m[9:0] = 10'h3ff;

    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_solved", solved, 1'b0);
    check("rst_conflict", conflict, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_iter", iter_cnt, '0);
    check("rst_mask", stg_mask_out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, grid,   6'd1,  1'b1, 1'b0, 1'b0, grid,   0, "solved_grid");
    run(0, zero_m, 6'd1,  1'b0, 1'b0, 1'b0, zero_m, 0, "converge_unsolved");
    run(0, bad,    6'd1,  1'b0, 1'b1, 1'b0, bad,    0, "conflict_over_converge");
    run(1, zero_m, 6'd3,  1'b0, 1'b1, 1'b0, conf_m, 0, "conflict_pass3");
    run(2, zero_m, 6'd32, 1'b0, 1'b0, 1'b1, add32,  0, "timeout");
    run(2, zero_m, 6'd32, 1'b0, 1'b0, 1'b1, add32,  5, "start_while_busy");

    // Reset in the middle of a solve once five passes have completed.
    @(negedge clk);
    mode    = 2;
    mask_in = '0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(posedge clk);
        #1;
        if (iter_cnt == 6'd5) begin
          hit = 1'b1;
          break;
        end
      end
      if (!hit) begin
        vectors++;
        errors++;
        $display("FAIL midrun_wait: got iter_cnt=%0d expected to reach 5", iter_cnt);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_solved", solved, 1'b0);
    check("midrst_conflict", conflict, 1'b0);
    check("midrst_timeout", timeout, 1'b0);
    check("midrst_iter", iter_cnt, '0);
    check("midrst_mask", stg_mask_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, grid, 6'd1, 1'b1, 1'b0, 1'b0, grid, 0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
